// File: rtl/uart_pkg.sv
// Shared types for the configurable UART transmitter: FSM state encoding and
// the data-length field encoding.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   typedef enum logic [1:0] {
      BITS_5 = 2'b00,
      BITS_6 = 2'b01,
      BITS_7 = 2'b10,
      BITS_8 = 2'b11
   } data_bits_e;

   function automatic logic [3:0] bits_count(input data_bits_e sel);
      return 4'd5 + {2'b00, sel};
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-time down-counter: reloads with div-1 on load and flags the last clock
// of a bit period when it reaches zero. A div of 0 behaves like 1.
module uart_baud_cnt #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [DIV_W-1:0] div,
   output logic             bit_end
);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] div_m1;

   assign div_m1  = (div == '0) ? '0 : div - DIV_W'(1);
   assign bit_end = (cnt_q == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= div_m1;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - DIV_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with per-frame configuration (5-8 data bits, optional
// parity, 1 or 2 stop bits, programmable baud divisor).
//
// state  | meaning
// IDLE   | line high, tx_ready, waiting for tx_valid
// START  | start bit (0) for one bit time
// DATA   | data bits LSB first, one bit time each
// PARITY | parity bit over the data bits (optional)
// STOP   | stop bit(s) high, tx_done on the last cycle
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int DIV_W    = 16,
   parameter int MAX_BITS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DIV_W-1:0]    baud_div,
   input  logic [1:0]          data_bits,
   input  logic                parity_en,
   input  logic                parity_odd,
   input  logic                stop2,
   input  logic                tx_valid,
   input  logic [MAX_BITS-1:0] tx_data,
   output logic                tx_ready,
   output logic                tx_serial,
   output logic                tx_busy,
   output logic                tx_done
);

   localparam int IDX_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

   uart_state_e         state_q, state_d;
   logic [MAX_BITS-1:0] data_q;
   logic [DIV_W-1:0]    div_q;
   data_bits_e          bits_q;
   logic                par_en_q;
   logic                par_odd_q;
   logic                stop2_q;
   logic [IDX_W-1:0]    bit_idx_q;
   logic                stop_second_q;

   logic                accept;
   logic                bit_end;
   logic                cnt_load;
   logic [DIV_W-1:0]    cnt_div;
   logic [3:0]          n_bits;
   logic [IDX_W-1:0]    last_idx;
   logic [MAX_BITS-1:0] data_mask;
   logic                parity_bit;

   assign tx_ready = (state_q == IDLE);
   assign tx_busy  = (state_q != IDLE);
   assign accept   = tx_valid && tx_ready;

   // The first bit time uses the live divisor since it is latched on the same edge.
   assign cnt_div  = (state_q == IDLE) ? baud_div : div_q;
   assign cnt_load = accept || (tx_busy && bit_end);

   uart_baud_cnt #(.DIV_W(DIV_W)) u_baud_cnt (
      .clk     (clk),
      .rst     (rst),
      .load    (cnt_load),
      .div     (cnt_div),
      .bit_end (bit_end)
   );

   assign n_bits   = bits_count(bits_q);
   assign last_idx = IDX_W'(n_bits - 4'd1);

   always_comb begin
      data_mask = '0;
      for (int i = 0; i < MAX_BITS; i++) begin
         data_mask[i] = (i < int'(n_bits));
      end
   end

   assign parity_bit = (^(data_q & data_mask)) ^ par_odd_q;

   always_comb begin
      state_d   = state_q;
      tx_serial = 1'b1;
      tx_done   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) state_d = START;
         end
         START: begin
            tx_serial = 1'b0;
            if (bit_end) state_d = DATA;
         end
         DATA: begin
            tx_serial = data_q[bit_idx_q];
            if (bit_end && (bit_idx_q == last_idx)) begin
               state_d = par_en_q ? PARITY : STOP;
            end
         end
         PARITY: begin
            tx_serial = parity_bit;
            if (bit_end) state_d = STOP;
         end
         STOP: begin
            if (bit_end && (!stop2_q || stop_second_q)) begin
               tx_done = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         data_q        <= '0;
         div_q         <= '0;
         bits_q        <= BITS_5;
         par_en_q      <= 1'b0;
         par_odd_q     <= 1'b0;
         stop2_q       <= 1'b0;
         bit_idx_q     <= '0;
         stop_second_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            data_q        <= tx_data;
            div_q         <= baud_div;
            bits_q        <= data_bits_e'(data_bits);
            par_en_q      <= parity_en;
            par_odd_q     <= parity_odd;
            stop2_q       <= stop2;
            bit_idx_q     <= '0;
            stop_second_q <= 1'b0;
         end
         if ((state_q == DATA) && bit_end) begin
            bit_idx_q <= (bit_idx_q == last_idx) ? '0 : bit_idx_q + IDX_W'(1);
         end
         // Toggles only with two stop bits, so it is back to 0 when the frame ends.
         if ((state_q == STOP) && bit_end) begin
            stop_second_q <= stop2_q && !stop_second_q;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg: captures each frame cycle by
// cycle and compares it against a bit-list model and hand-computed lengths.
module tb_uart_tx_cfg;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] baud_div;
   logic [1:0]  data_bits;
   logic        parity_en;
   logic        parity_odd;
   logic        stop2;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        tx_serial;
   logic        tx_busy;
   logic        tx_done;

   int n_checks = 0;
   int n_fail   = 0;

   uart_tx_cfg #(.DIV_W(16), .MAX_BITS(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .baud_div   (baud_div),
      .data_bits  (data_bits),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .stop2      (stop2),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .tx_serial  (tx_serial),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected line, one bit per cycle starting at the first START cycle.
   function automatic logic [127:0] model(input logic [7:0] d, input int div, input int nb,
                                          input bit pe, input bit po, input bit s2);
      logic [127:0] v;
      int           p;
      int           tot;
      bit           par;
      logic         b;
      v   = '0;
      p   = 0;
      par = po;
      tot = 2 + nb + int'(pe) + int'(s2);
      for (int k = 0; k < tot; k++) begin
         if (k == 0) b = 1'b0;
         else if (k <= nb) begin
            b   = d[k-1];
            par = par ^ b;
         end
         else if (pe && (k == nb + 1)) b = par;
         else b = 1'b1;
         for (int r = 0; r < div; r++) begin
            v[p] = b;
            p++;
         end
      end
      return v;
   endfunction

   // Called at the negedge of the first START cycle; returns at the tx_done cycle.
   task automatic capture(input int chg_at, output logic [127:0] obs, output int len,
                          output int bad);
      obs = '0;
      len = 0;
      bad = 0;
      for (int c = 1; c <= 200; c++) begin
         if (c <= 128) obs[c-1] = tx_serial;
         if (!tx_busy || tx_ready) bad++;
         if (c == chg_at) begin
            baud_div  = 16'd2;
            data_bits = 2'b00;
            tx_data   = 8'h13;
         end
         if (tx_done) begin
            len = c;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic send(input logic [7:0] d, input logic [15:0] div, input logic [1:0] bits,
                       input logic pe, input logic po, input logic s2, input int chg_at,
                       output logic [127:0] obs, output int len, output int bad);
      tx_data    = d;
      baud_div   = div;
      data_bits  = bits;
      parity_en  = pe;
      parity_odd = po;
      stop2      = s2;
      tx_valid   = 1'b1;
      @(negedge clk);
      tx_valid   = 1'b0;
      capture(chg_at, obs, len, bad);
   endtask

   task automatic check_frame(input string tag, input logic [127:0] obs, input int len,
                              input int bad, input int exp_len, input logic [127:0] exp_pat);
      chk({tag, "_len"},  128'(len), 128'(exp_len));
      chk({tag, "_line"}, obs, exp_pat);
      chk({tag, "_busy"}, 128'(bad), 128'd0);
   endtask

   task automatic idle_check(input string tag);
      @(negedge clk);
      chk({tag, "_idle_ser"},  128'(tx_serial), 128'd1);
      chk({tag, "_idle_busy"}, 128'(tx_busy),   128'd0);
      chk({tag, "_idle_rdy"},  128'(tx_ready),  128'd1);
   endtask

   initial begin
      logic [127:0] obs;
      int           len;
      int           bad;
      int           dones;

      rst        = 1'b1;
      baud_div   = '0;
      data_bits  = '0;
      parity_en  = 1'b0;
      parity_odd = 1'b0;
      stop2      = 1'b0;
      tx_valid   = 1'b0;
      tx_data    = '0;
      repeat (3) @(negedge clk);
      chk("rst_serial", 128'(tx_serial), 128'd1);
      chk("rst_busy",   128'(tx_busy),   128'd0);
      chk("rst_done",   128'(tx_done),   128'd0);
      rst = 1'b0;
      idle_check("post_rst");

      // 8N1, div 4, 0xA5: line 0,1,0,1,0,0,1,0,1,1
      send(8'hA5, 16'd4, 2'b11, 1'b0, 1'b0, 1'b0, 0, obs, len, bad);
      check_frame("8n1", obs, len, bad, 40, model(8'hA5, 4, 8, 0, 0, 0));
      idle_check("8n1");

      // 7E2, div 3, 0x55: bit7 ignored, parity 0
      send(8'h55, 16'd3, 2'b10, 1'b1, 1'b0, 1'b1, 0, obs, len, bad);
      check_frame("7e2", obs, len, bad, 33, model(8'h55, 3, 7, 1, 0, 1));
      chk("7e2_parity", 128'(obs[25]), 128'd0);
      idle_check("7e2");

      // 5O1, div 1, 0x1F: parity 0
      send(8'h1F, 16'd1, 2'b00, 1'b1, 1'b1, 1'b0, 0, obs, len, bad);
      check_frame("5o1", obs, len, bad, 8, model(8'h1F, 1, 5, 1, 1, 0));
      chk("5o1_parity", 128'(obs[6]), 128'd0);
      idle_check("5o1");

      // baud_div 0 behaves as 1
      send(8'h3C, 16'd0, 2'b11, 1'b0, 1'b0, 1'b0, 0, obs, len, bad);
      check_frame("div0", obs, len, bad, 10, model(8'h3C, 1, 8, 0, 0, 0));
      idle_check("div0");

      // Back-to-back with tx_valid held: exactly one idle cycle between frames
      tx_data    = 8'h00;
      baud_div   = 16'd2;
      data_bits  = 2'b11;
      parity_en  = 1'b0;
      parity_odd = 1'b0;
      stop2      = 1'b0;
      tx_valid   = 1'b1;
      @(negedge clk);
      tx_data = 8'hFF;
      capture(0, obs, len, bad);
      check_frame("b2b0", obs, len, bad, 20, model(8'h00, 2, 8, 0, 0, 0));
      idle_check("b2b_gap");
      @(negedge clk);
      tx_valid = 1'b0;
      capture(0, obs, len, bad);
      check_frame("b2b1", obs, len, bad, 20, model(8'hFF, 2, 8, 0, 0, 0));
      idle_check("b2b1");

      // Mid-frame change of baud_div/data_bits/tx_data; next frame uses new values
      send(8'hA5, 16'd4, 2'b11, 1'b0, 1'b0, 1'b0, 10, obs, len, bad);
      check_frame("chg_cur", obs, len, bad, 40, model(8'hA5, 4, 8, 0, 0, 0));
      idle_check("chg_cur");
      send(tx_data, baud_div, data_bits, 1'b0, 1'b0, 1'b0, 0, obs, len, bad);
      check_frame("chg_next", obs, len, bad, 14, model(8'h13, 2, 5, 0, 0, 0));
      idle_check("chg_next");

      // Reset during DATA aborts the frame without tx_done
      send(8'hA5, 16'd4, 2'b11, 1'b0, 1'b0, 1'b0, 0, obs, len, bad);
      chk("abort_len", 128'(len), 128'd40);
      idle_check("pre_abort");
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      dones = 0;
      repeat (7) begin
         if (tx_done) dones++;
         @(negedge clk);
      end
      chk("abort_in_frame", 128'(tx_busy), 128'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_serial", 128'(tx_serial), 128'd1);
      chk("abort_busy",   128'(tx_busy),   128'd0);
      rst = 1'b0;
      for (int c = 0; c < 60; c++) begin
         if (tx_done) dones++;
         @(negedge clk);
      end
      chk("abort_no_done", 128'(dones), 128'd0);
      chk("abort_ready",   128'(tx_ready), 128'd1);
      chk("abort_idle",    128'(tx_serial), 128'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
